// File: rtl/tt_counter_pkg.sv
// Shared constants for the counter front end: channel indices and debounce defaults.
package tt_counter_pkg;

    localparam int unsigned CH_INC   = 0;
    localparam int unsigned CH_DEC   = 1;
    localparam int unsigned CH_LOAD  = 2;
    localparam int unsigned CH_PAUSE = 3;

    localparam int unsigned N_CH_DEF            = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned SYNC_STAGES_DEF     = 2;

    // Stability counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel conditioner: synchroniser, stability counter, level and edge pulses.
module debounce_ch
    import tt_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_d, rise_d, fall_d;

    // Synchroniser runs regardless of ena so it is settled when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Level only flips after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (ena && (s != level)) begin
            if (cnt_q == CNT_MAX) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            level <= level_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

endmodule

// File: rtl/btn_debounce_edge.sv
// Multi-channel button/switch conditioner feeding the counter core.
module btn_debounce_edge
    import tt_counter_pkg::*;
#(
    parameter int unsigned N_CH            = N_CH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .din   (btn_in[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Scoreboard bench for btn_debounce_edge with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_btn_debounce_edge;

    localparam int unsigned N_CH = 4;
    localparam int unsigned D    = 4;
    localparam int unsigned SS   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level, btn_rise, btn_fall;

    typedef struct packed {
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: two-stage input history and per-channel mismatch run length.
    logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    int              m_run [N_CH];

    logic [N_CH-1:0] obs_lvl, obs_rise, obs_fall;

    btn_debounce_edge #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    endtask

    // Advance the model by one rising edge seeing inputs b and enable e.
    task automatic model_step(input logic [N_CH-1:0] b, input logic e);
        for (int c = 0; c < N_CH; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (!e || (m_s2[c] == m_lvl[c])) begin
                m_run[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == int'(D)) begin
                    m_lvl[c]  = m_s2[c];
                    m_rise[c] = m_s2[c];
                    m_fall[c] = ~m_s2[c];
                    m_run[c]  = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic tick(input logic [N_CH-1:0] b, input logic e);
        exp_t x;
        btn_in = b;
        ena    = e;
        model_step(b, e);
        x = {m_lvl, m_rise, m_fall};
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        obs_lvl  = btn_level;
        obs_rise = btn_rise;
        obs_fall = btn_fall;
        x = sb_q.pop_front();
        check_val("level", 32'(obs_lvl), 32'(x.lvl));
        check_val("rise", 32'(obs_rise), 32'(x.rise));
        check_val("fall", 32'(obs_fall), 32'(x.fall));
        check_val("rise_fall_excl", 32'(obs_rise & obs_fall), 32'd0);
    endtask

    task automatic reset_assert(input string tag);
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        check_val({tag, "_level"}, 32'(btn_level), 32'd0);
        check_val({tag, "_rise"}, 32'(btn_rise), 32'd0);
        check_val({tag, "_fall"}, 32'(btn_fall), 32'd0);
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int cnt;
        logic [N_CH-1:0] seen;

        // 1. Reset with all buttons held; re-qualification after release.
        btn_in = 4'hF;
        ena    = 1'b1;
        reset_assert("t1_reset");
        reset_release();
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(4'hF, 1'b1);
            if (first == 0 && obs_rise != 0) begin
                first = i;
                check_val("t1_rise_val", 32'(obs_rise), 32'hF);
                check_val("t1_level_val", 32'(obs_lvl), 32'hF);
            end
        end
        check_val("t1_rise_edge", 32'(first), 32'd6);
        for (int i = 0; i < 10; i++) tick(4'h0, 1'b1);

        // 2. Clean press/release on ch0.
        first = 0;
        cnt   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(4'h1, 1'b1);
            if (first == 0 && obs_rise[0]) first = i;
            if (obs_lvl[0]) cnt++;
        end
        check_val("t2_rise_delay", 32'(first), 32'd6);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(4'h0, 1'b1);
            if (first == 0 && obs_fall[0]) first = i;
            if (obs_lvl[0]) cnt++;
        end
        check_val("t2_fall_delay", 32'(first), 32'd6);
        check_val("t2_level_len", 32'(cnt), 32'd20);

        // 3. Glitchy ch1 never qualifies.
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            tick(((i < 3) || (i >= 4 && i < 7)) ? 4'h2 : 4'h0, 1'b1);
            if (obs_rise[1] || obs_lvl[1]) cnt++;
        end
        check_val("t3_no_rise", 32'(cnt), 32'd0);

        // 4. ena gating on ch2.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(4'h4, 1'b0);
            if (obs_rise != 0 || obs_fall != 0) cnt++;
        end
        check_val("t4_no_pulse_disabled", 32'(cnt), 32'd0);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(4'h4, 1'b1);
            if (first == 0 && obs_rise[2]) first = i;
        end
        check_val("t4_rise_after_ena", 32'(first), 32'd4);
        for (int i = 0; i < 10; i++) tick(4'h0, 1'b1);

        // 5. Reset in the middle of qualifying ch3.
        for (int i = 0; i < 4; i++) tick(4'h8, 1'b1);
        reset_assert("t5_reset");
        reset_release();
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(4'h8, 1'b1);
            if (first == 0 && obs_rise[3]) first = i;
        end
        check_val("t5_rise_after_release", 32'(first), 32'd6);
        for (int i = 0; i < 10; i++) tick(4'h0, 1'b1);

        // 6. Simultaneous transitions on ch0 and ch2.
        cnt  = 0;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick(4'h5, 1'b1);
            if (obs_rise != 0) begin
                cnt++;
                seen = obs_rise;
                check_val("t6_fall_zero", 32'(obs_fall), 32'd0);
            end
        end
        check_val("t6_rise_cycles", 32'(cnt), 32'd1);
        check_val("t6_rise_val", 32'(seen), 32'h5);

        // Asynchronous clear of an established level.
        check_val("t7_level_before", 32'(btn_level), 32'h5);
        reset_assert("t7_reset");
        reset_release();
        tick(4'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
